// File: rtl/ucie_rdi_tx_stall_ctrl.sv
// RDI transmit-side stall controller.
// Buffers upstream beats in a 2-entry FIFO and forwards them to the RDI transmit port.
// A small FSM keeps packets whole across PHY stall requests: once a packet has started,
// it is allowed to finish, then intake closes, the FIFO drains and the stall is acknowledged.
//
// Ports
//   clk, resetn                    clock, asynchronous active-low reset
//   s_valid/s_ready                upstream beat handshake
//   s_data/s_user/s_sop/s_eop/s_empty  upstream beat payload and framing
//   tx_valid/tx_ready              RDI transmit handshake
//   tx_data/tx_user/tx_sop/tx_eop/tx_empty  RDI transmit beat (FIFO head)
//   pl_stallreq/lp_stallack        PHY stall request / registered acknowledge
//   link_up                        RDI link active; gates the start of new packets only
//   pkt_count                      packets fully sent (wrapping)
//   proto_err                      one-cycle pulse after a framing violation
module ucie_rdi_tx_stall_ctrl #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned USER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [USER_WIDTH-1:0] s_user,
  input  logic                  s_sop,
  input  logic                  s_eop,
  input  logic [5:0]            s_empty,
  output logic                  s_ready,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [USER_WIDTH-1:0] tx_user,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic [5:0]            tx_empty,
  input  logic                  tx_ready,
  input  logic                  pl_stallreq,
  output logic                  lp_stallack,
  input  logic                  link_up,
  output logic [15:0]           pkt_count,
  output logic                  proto_err
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [USER_WIDTH-1:0] user;
    logic                  sop;
    logic                  eop;
    logic [5:0]            empty;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StInPkt, StDrain, StStalled} state_e;

  state_e      state_q, state_d;
  entry_t      mem_q [2];
  entry_t      head;
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic        proto_err_q, proto_err_d;
  logic        lp_stallack_q;
  logic        gate, accept, pop;

  // Datapath handshakes
  always_comb begin
    head     = mem_q[rd_ptr_q];
    tx_valid = (count_q != 2'd0);
    pop      = tx_valid & tx_ready;

    gate = 1'b0;
    unique case (state_q)
      StIdle:  gate = link_up & ~pl_stallreq;
      StInPkt: gate = 1'b1; // an open packet always completes, even if the link drops
      default: gate = 1'b0;
    endcase

    // resetn term holds s_ready low for the whole time reset is asserted
    s_ready = resetn & (count_q != 2'd2) & gate;
    accept  = s_valid & s_ready;

    count_d = count_q;
    unique case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    pkt_count_d = pkt_count_q;
    if (pop && head.eop) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      pkt_count_q <= 16'd0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= '{data: s_data, user: s_user, sop: s_sop, eop: s_eop,
                             empty: s_empty};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Framing / stall FSM
  always_comb begin
    state_d     = state_q;
    proto_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          proto_err_d = ~s_sop;
          if (s_sop && !s_eop) begin
            state_d = StInPkt;
          end
        end else if (pl_stallreq) begin
          state_d = StDrain;
        end
      end
      StInPkt: begin
        if (accept) begin
          proto_err_d = s_sop;
          if (s_eop) begin
            state_d = pl_stallreq ? StDrain : StIdle;
          end
        end
      end
      StDrain: begin
        // Uses the registered count: a pop that empties the FIFO is seen next cycle
        if (!pl_stallreq) begin
          state_d = StIdle;
        end else if (count_q == 2'd0) begin
          state_d = StStalled;
        end
      end
      StStalled: begin
        if (!pl_stallreq) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      proto_err_q   <= 1'b0;
      lp_stallack_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      proto_err_q   <= proto_err_d;
      lp_stallack_q <= (state_d == StStalled);
    end
  end

  assign tx_data     = head.data;
  assign tx_user     = head.user;
  assign tx_sop      = head.sop;
  assign tx_eop      = head.eop;
  assign tx_empty    = head.empty;
  assign pkt_count   = pkt_count_q;
  assign proto_err   = proto_err_q;
  assign lp_stallack = lp_stallack_q;

endmodule
